crc16_frame_ctrl: RTL and testbench

CRC16_FRAME_CTRL -- requirements
Module: crc16_frame_ctrl

---
 rtl/crc16_frame_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_crc16_frame_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/crc16_frame_ctrl.sv
// CRC-16 (x^16+x^12+x^5+1) frame controller: byte in, MSB-first serial out.
// Optional CRC16_CHECK_EN adds receive-check mode (chk input, crc_err output).
module crc16_frame_ctrl #(
    parameter logic [15:0] INIT  = 16'h0000,
    parameter int          LEN_W = 8
) (
    input  logic             Clk,
    input  logic             R,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
`ifdef CRC16_CHECK_EN
    input  logic             chk,
    output logic             crc_err,
`endif
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done,
    output logic [15:0]      crc_out
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        APPEND,
        DONE
    } state_t;

    state_t           state_q;
    logic [15:0]      lfsr_q;
    logic [15:0]      lfsr_d;
    logic [LEN_W-1:0] rem_q;
    logic [LEN_W-1:0] rem_d;
    logic [7:0]       sh_q;
    logic [15:0]      app_q;
    logic [3:0]       bit_q;
    logic [15:0]      crc_q;
    logic             chk_q;
    logic             chk_in;
    logic             in_ready_q;
    logic             ser_out_q;
    logic             ser_valid_q;
    logic             busy_q;
    logic             done_q;

`ifdef CRC16_CHECK_EN
    logic err_q;
    assign chk_in  = chk;
    assign crc_err = err_q;
`else
    assign chk_in  = 1'b0;
`endif

    // One LFSR step driven by the bit currently on the serial output
    always_comb begin
        lfsr_d = {lfsr_q[14:0], 1'b0};
        if (ser_out_q ^ lfsr_q[15]) begin
            lfsr_d = lfsr_d ^ 16'h1021;
        end
        rem_d = rem_q - {{(LEN_W-1){1'b0}}, 1'b1};
    end

    // Frame FSM with registered outputs computed for the state being entered
    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            state_q     <= IDLE;
            lfsr_q      <= INIT;
            rem_q       <= '0;
            sh_q        <= '0;
            app_q       <= '0;
            bit_q       <= '0;
            crc_q       <= '0;
            chk_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef CRC16_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else if (abort && state_q != IDLE) begin
            state_q     <= IDLE;
            bit_q       <= '0;
            in_ready_q  <= 1'b0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rem_q  <= len;
                        lfsr_q <= INIT;
                        bit_q  <= '0;
                        chk_q  <= chk_in;
                        busy_q <= 1'b1;
`ifdef CRC16_CHECK_EN
                        err_q  <= 1'b0;
`endif
                        if (len != '0) begin
                            state_q    <= LOAD;
                            in_ready_q <= 1'b1;
                        end else if (chk_in) begin
                            // Nothing received: report INIT as the residue
                            state_q <= DONE;
                            crc_q   <= INIT;
                            done_q  <= 1'b1;
`ifdef CRC16_CHECK_EN
                            err_q   <= (INIT != 16'h0000);
`endif
                        end else begin
                            state_q     <= APPEND;
                            crc_q       <= INIT;
                            app_q       <= {INIT[14:0], 1'b0};
                            ser_out_q   <= INIT[15];
                            ser_valid_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        state_q     <= SHIFT;
                        sh_q        <= {in_data[6:0], 1'b0};
                        ser_out_q   <= in_data[7];
                        ser_valid_q <= 1'b1;
                        in_ready_q  <= 1'b0;
                        bit_q       <= '0;
                    end
                end
                SHIFT: begin
                    lfsr_q <= lfsr_d;
                    bit_q  <= bit_q + 4'd1;
                    if (bit_q != 4'd7) begin
                        ser_out_q <= sh_q[7];
                        sh_q      <= {sh_q[6:0], 1'b0};
                    end else begin
                        rem_q <= rem_d;
                        bit_q <= '0;
                        if (rem_d != '0) begin
                            state_q     <= LOAD;
                            in_ready_q  <= 1'b1;
                            ser_out_q   <= 1'b0;
                            ser_valid_q <= 1'b0;
                        end else if (chk_q) begin
                            state_q     <= DONE;
                            crc_q       <= lfsr_d;
                            done_q      <= 1'b1;
                            ser_out_q   <= 1'b0;
                            ser_valid_q <= 1'b0;
`ifdef CRC16_CHECK_EN
                            err_q       <= (lfsr_d != 16'h0000);
`endif
                        end else begin
                            state_q   <= APPEND;
                            crc_q     <= lfsr_d;
                            app_q     <= {lfsr_d[14:0], 1'b0};
                            ser_out_q <= lfsr_d[15];
                        end
                    end
                end
                APPEND: begin
                    bit_q <= bit_q + 4'd1;
                    if (bit_q != 4'd15) begin
                        ser_out_q <= app_q[15];
                        app_q     <= {app_q[14:0], 1'b0};
                    end else begin
                        state_q     <= DONE;
                        bit_q       <= '0;
                        done_q      <= 1'b1;
                        ser_out_q   <= 1'b0;
                        ser_valid_q <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign crc_out   = crc_q;

endmodule

// File: tb/tb_crc16_frame_ctrl.sv
// Bench for crc16_frame_ctrl: directed and random frames checked against
// a polynomial long-division CRC model and a serial bit-stream model.
module tb_crc16_frame_ctrl;

    logic        Clk = 1'b0;
    logic        R = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic        abort = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        ser_out;
    logic        ser_valid;
    logic        busy;
    logic        done;
    logic [15:0] crc_out;
`ifdef CRC16_CHECK_EN
    logic        chk = 1'b0;
    logic        crc_err;
`endif

    crc16_frame_ctrl dut (
        .Clk      (Clk),
        .R        (R),
        .start    (start),
        .len      (len),
        .abort    (abort),
        .in_data  (in_data),
        .in_valid (in_valid),
`ifdef CRC16_CHECK_EN
        .chk      (chk),
        .crc_err  (crc_err),
`endif
        .in_ready (in_ready),
        .ser_out  (ser_out),
        .ser_valid(ser_valid),
        .busy     (busy),
        .done     (done),
        .crc_out  (crc_out)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad = 0;

    logic [7:0] payload[$];
    bit         got[$];
    int         done_cyc;
    int         ir_seen;
    int         hs_cnt;
    logic [15:0] last_crc;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // CRC of the payload as remainder of M(x)*x^16 mod P(x), INIT = 0
    function automatic logic [15:0] ref_crc();
        logic [16:0] r;
        r = '0;
        for (int i = 0; i < payload.size() * 8 + 16; i++) begin
            bit b;
            b = (i < payload.size() * 8) ? payload[i / 8][7 - (i % 8)] : 1'b0;
            r = {r[15:0], b};
            if (r[16]) r = r ^ 17'h11021;
        end
        return r[15:0];
    endfunction

    task automatic run_frame(input int n, input string tag, input bit cm);
        int  cyc;
        int  guard;
        int  nbad;
        bit  fin;
        bit  hs;
        bit  expq[$];
        logic [15:0] exp_crc;
        got.delete();
        done_cyc = -1;
        ir_seen  = 0;
        hs_cnt   = 0;
        fin      = 1'b0;
        guard    = 0;
        len      = 8'(n);
        start    = 1'b1;
`ifdef CRC16_CHECK_EN
        chk = cm;
`endif
        step();
        start = 1'b0;
        cyc   = 1;
        while (!fin && guard < 20000) begin
            guard++;
            hs = 1'b0;
            if (ser_valid) got.push_back(ser_out);
            if (in_ready) ir_seen++;
            if (done) begin
                done_cyc = cyc;
                fin      = 1'b1;
            end else begin
                start    = ($urandom_range(0, 3) == 0);
                len      = 8'($urandom);
                in_data  = 8'($urandom);
                in_valid = 1'($urandom);
                if (in_ready && in_valid && hs_cnt < payload.size()) begin
                    in_data = payload[hs_cnt];
                    hs_cnt++;
                    hs = 1'b1;
                end
                step();
                cyc = hs ? 1 : cyc + 1;
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        check({tag, "_done_seen"}, 32'(fin), 1);
        check({tag, "_handshakes"}, hs_cnt, n);
        check({tag, "_latency"}, done_cyc, cm ? 9 : (n == 0 ? 17 : 25));
        exp_crc = ref_crc();
        foreach (payload[i])
            for (int k = 7; k >= 0; k--) expq.push_back(payload[i][k]);
        if (!cm)
            for (int k = 15; k >= 0; k--) expq.push_back(exp_crc[k]);
        check({tag, "_nbits"}, got.size(), expq.size());
        nbad = 0;
        foreach (expq[i])
            if (i >= got.size() || got[i] !== expq[i]) nbad++;
        check({tag, "_bits"}, nbad, 0);
        check({tag, "_crc"}, crc_out, exp_crc);
        last_crc = exp_crc;
        step();
        check({tag, "_done_1cyc"}, {done, busy}, 0);
    endtask

    initial begin
        logic [15:0] tail;
        int          dcount;
        int          n;

        #12;
        check("rst_outs", {in_ready, ser_out, ser_valid, busy, done}, 0);
        check("rst_crc", crc_out, 0);
`ifdef CRC16_CHECK_EN
        check("rst_err", crc_err, 0);
`endif
        @(negedge Clk);
        R = 1'b1;
        step();

        payload = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                    8'h36, 8'h37, 8'h38, 8'h39};
        run_frame(9, "chk123", 1'b0);
        check("chk123_const", crc_out, 16'h31C3);
        tail = '0;
        for (int i = 0; i < 16; i++)
            if (got.size() >= 16) tail = {tail[14:0], 1'(got[got.size() - 16 + i])};
        check("chk123_append", tail, 16'h31C3);

        payload = '{8'h01};
        run_frame(1, "one", 1'b0);
        check("one_const", crc_out, 16'h1021);

        payload = '{};
        run_frame(0, "empty", 1'b0);
        check("empty_no_ready", ir_seen, 0);
        check("empty_crc", crc_out, 16'h0000);

        payload = '{8'h5A};
        run_frame(1, "pre_abort", 1'b0);
        len      = 8'd1;
        start    = 1'b1;
        step();
        start    = 1'b0;
        in_data  = 8'hA5;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_idle", {busy, ser_valid, in_ready, done}, 0);
        check("abort_crc_kept", crc_out, last_crc);
        dcount = 0;
        for (int i = 0; i < 30; i++) begin
            if (done || busy) dcount++;
            step();
        end
        check("abort_no_done", dcount, 0);
        payload = '{8'h01};
        run_frame(1, "post_abort", 1'b0);
        check("post_abort_const", crc_out, 16'h1021);

        len      = 8'd2;
        start    = 1'b1;
        step();
        start    = 1'b0;
        in_data  = 8'h5A;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        check("pre_rst_busy", {busy, ser_valid}, 2'b11);
        #2;
        R = 1'b0;
        #1;
        check("async_rst_outs", {in_ready, ser_out, ser_valid, busy, done}, 0);
        check("async_rst_crc", crc_out, 0);
        step();
        step();
        @(negedge Clk);
        R = 1'b1;
        step();
        payload = '{8'hC3, 8'h7E};
        run_frame(2, "post_rst", 1'b0);

        for (int t = 0; t < 4; t++) begin
            n = $urandom_range(1, 6);
            payload = '{};
            for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
            run_frame(n, $sformatf("rnd%0d", t), 1'b0);
        end

        payload = '{};
        for (int i = 0; i < 255; i++) payload.push_back(8'($urandom));
        run_frame(255, "maxlen", 1'b0);

`ifdef CRC16_CHECK_EN
        payload = '{8'h01, 8'h10, 8'h21};
        run_frame(3, "rx_good", 1'b1);
        check("rx_good_err", crc_err, 0);
        payload = '{8'h01, 8'h10, 8'h20};
        run_frame(3, "rx_bad", 1'b1);
        check("rx_bad_err", crc_err, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
